apb_mem_slave: RTL and testbench

//  APB3 completer sitting directly upstream of the 1-cycle-latency synchronous RAM.

---
 rtl/apb_mem_slave_if.sv | 25 ++
 rtl/apb_mem_slave.sv | 132 +++++++++++++
 tb/tb_apb_mem_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_if.sv
// APB3 completer-side bus bundle between the system interconnect and apb_mem_slave.
// The requester drives select/enable/address/write data; the completer returns read data, ready and error.
interface apb_mem_slave_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 completer in front of a 1-cycle-latency sync RAM; writes/errors complete with 0 wait states, reads with 1.
// Backpressure: pready is held low for exactly one access cycle on reads; dropping psel aborts to IDLE.
module apb_mem_slave #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    apb_mem_slave_if.slave        apb,
    output logic                  mem_wr_en_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int BOFF = $clog2(DATA_WIDTH / 8);

    // Byte-lane offset bits must be zero; bits above the RAM span must be zero (no aliasing).
    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK =
        APB_ADDR_WIDTH'((64'd1 << BOFF) - 64'd1);
    localparam logic [APB_ADDR_WIDTH-1:0] SPAN_MASK =
        APB_ADDR_WIDTH'((64'd1 << (BOFF + ADDR_WIDTH)) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ACC,
        RD_REQ,
        RD_DATA,
        ERR_ACC
    } state_t;

    state_t                r_state;
    state_t                w_nxt_state;
    logic                  r_pready;
    logic                  r_pslverr;
    logic                  r_mem_wr_en;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_nxt_pready;
    logic                  w_nxt_pslverr;
    logic                  w_nxt_wr_en;
    logic                  w_nxt_rd_en;
    logic                  w_latch;
    logic                  w_setup;
    logic                  w_bad_addr;

    assign w_setup    = apb.psel && !apb.penable;
    assign w_bad_addr = (|(apb.paddr & ALIGN_MASK)) || (|(apb.paddr & ~SPAN_MASK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_pready  = 1'b0;
        w_nxt_pslverr = 1'b0;
        w_nxt_wr_en   = 1'b0;
        w_nxt_rd_en   = 1'b0;
        w_latch       = 1'b0;
        case (r_state)
            IDLE: begin
                // An access phase without a preceding setup is not a transfer we own.
                if (w_setup) begin
                    w_latch = 1'b1;
                    if (w_bad_addr) begin
                        w_nxt_state   = ERR_ACC;
                        w_nxt_pready  = 1'b1;
                        w_nxt_pslverr = 1'b1;
                    end else if (apb.pwrite) begin
                        w_nxt_state  = WR_ACC;
                        w_nxt_pready = 1'b1;
                        w_nxt_wr_en  = 1'b1;
                    end else begin
                        w_nxt_state = RD_REQ;
                        w_nxt_rd_en = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (apb.psel) begin
                    w_nxt_state  = RD_DATA;
                    w_nxt_pready = 1'b1;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            WR_ACC, RD_DATA, ERR_ACC: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_pready    <= w_nxt_pready;
            r_pslverr   <= w_nxt_pslverr;
            r_mem_wr_en <= w_nxt_wr_en;
            r_mem_rd_en <= w_nxt_rd_en;
            if (w_latch) begin
                r_mem_addr  <= apb.paddr[BOFF +: ADDR_WIDTH];
                r_mem_wdata <= apb.pwdata;
            end
        end
    end

    // RAM data arrives the cycle after the read strobe, which is exactly RD_DATA.
    assign apb.prdata  = (r_state == RD_DATA) ? mem_rdata_i : '0;
    assign apb.pready  = r_pready;
    assign apb.pslverr = r_pslverr;
    assign mem_wr_en_o = r_mem_wr_en;
    assign mem_rd_en_o = r_mem_rd_en;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomised APB traffic against apb_mem_slave with a 1-cycle RAM behind it.
// Expected completions and RAM strobes are queued at issue time and checked by a separate monitor.
module tb_apb_mem_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ram [0:1023] = '{default: '0};

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } strb_t;

    exp_t        q_exp[$];
    strb_t       q_strb[$];
    logic [31:0] model_mem [int];

    apb_mem_slave_if #(.APB_ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    apb_mem_slave #(.APB_ADDR_WIDTH(32), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .apb         (apb),
        .mem_wr_en_o (mem_wr_en),
        .mem_rd_en_o (mem_rd_en),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Synchronous RAM with one cycle read latency; contents survive reset.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 1024-word memory, byte addressed, word aligned, no aliasing.
    function automatic bit model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4096);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx = int'(a / 4);
        return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    endfunction

    task automatic monitor();
        int    waits = 0;
        exp_t  e;
        strb_t s;
        forever begin
            @(negedge clk);
            if (reset) begin
                waits = 0;
                continue;
            end
            if (mem_wr_en || mem_rd_en) begin
                if (q_strb.size() == 0) begin
                    chk("spurious_strobe", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
                end else begin
                    s = q_strb.pop_front();
                    chk("strobe_wr", 32'(mem_wr_en), 32'(s.wr));
                    chk("strobe_rd", 32'(mem_rd_en), 32'(!s.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(s.addr));
                    if (s.wr) chk("mem_wdata", mem_wdata, s.wdata);
                end
            end
            if (!apb.pready) begin
                chk("pslverr_not_ready", 32'(apb.pslverr), 32'd0);
                chk("prdata_not_ready", apb.prdata, 32'd0);
            end
            if (apb.psel && apb.penable) begin
                if (apb.pready) begin
                    if (q_exp.size() == 0) begin
                        chk("unexpected_ready", 32'd1, 32'd0);
                    end else begin
                        e = q_exp.pop_front();
                        chk("pslverr", 32'(apb.pslverr), 32'(e.err));
                        chk("prdata", apb.prdata, e.data);
                        chk("wait_states", 32'(waits), 32'(e.waits));
                    end
                    waits = 0;
                end else begin
                    waits++;
                end
            end else begin
                waits = 0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 so a following call is back-to-back.
    task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit abort);
        bit   err = model_err(a);
        exp_t e;
        int   n;
        if (!err) begin
            q_strb.push_back('{wr: wr, addr: 10'(a / 4), wdata: d});
            if (wr) model_mem[int'(a / 4)] = d;
        end
        e.err   = err;
        e.rd    = !wr;
        e.data  = (!wr && !err) ? model_read(a) : 32'h0;
        e.waits = (!wr && !err) ? 1 : 0;
        if (!abort) q_exp.push_back(e);

        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = a;
        apb.pwdata  = d;
        @(posedge clk);
        #1;
        if (abort) begin
            apb.psel    = 1'b0;
            apb.penable = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_pready", 32'(apb.pready), 32'd0);
            return;
        end
        apb.penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!apb.pready && n < 6);
        if (!apb.pready) chk("pready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        bit          wr;
        int          kind;
        reset       = 1'b1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 32'h10;
        apb.pwdata  = 32'hCAFE_F00D;
        fork
            monitor();
        join_none

        // Reset held with a setup pending: nothing may happen.
        idle(3);
        chk("rst_pready", 32'(apb.pready), 32'd0);
        chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
        chk("rst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        chk("rst_prdata", apb.prdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset    = 1'b0;
        apb.psel = 1'b0;
        idle(2);
        chk("post_rst_pready", 32'(apb.pready), 32'd0);

        apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        apb_xfer(1'b0, 32'h10, 32'h0, 1'b0);
        idle(1);
        apb_xfer(1'b0, 32'h13, 32'h0, 1'b0);
        apb_xfer(1'b1, 32'h1000, 32'h5555_5555, 1'b0);
        apb_xfer(1'b1, 32'h3FFC, 32'h7777_7777, 1'b0);

        // Back-to-back, including the last word of the RAM.
        apb_xfer(1'b1, 32'h0, 32'h1111, 1'b0);
        apb_xfer(1'b1, 32'hFFC, 32'h2222, 1'b0);
        apb_xfer(1'b0, 32'h0, 32'h0, 1'b0);
        apb_xfer(1'b0, 32'hFFC, 32'h0, 1'b0);

        // Reset while the read strobe is out.
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = 32'h10;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        chk("midrst_pready", 32'(apb.pready), 32'd0);
        apb.psel = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        apb_xfer(1'b0, 32'h10, 32'h0, 1'b0);

        // Access phase with no setup is ignored.
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
        apb.pwrite  = 1'b1;
        apb.paddr   = 32'h20;
        idle(2);
        chk("no_setup_pready", 32'(apb.pready), 32'd0);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        idle(1);

        // Aborts: the write strobe still lands in the RAM.
        apb_xfer(1'b1, 32'h40, 32'hABCD_0123, 1'b1);
        apb_xfer(1'b0, 32'h40, 32'h0, 1'b1);
        apb_xfer(1'b0, 32'h41, 32'h0, 1'b1);
        apb_xfer(1'b0, 32'h40, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)
                a = ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
            else if (kind == 1)
                a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
            else if (kind == 2)
                a = 32'hFFC;
            else
                a = $urandom_range(0, 15) * 4;
            wr = 1'($urandom_range(0, 1));
            apb_xfer(wr, a, $urandom, $urandom_range(0, 15) == 0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        chk("strobe_queue_empty", 32'(q_strb.size()), 32'd0);
        chk("completion_queue_empty", 32'(q_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
